// File: rtl/param_cpu_core.sv
// param_cpu_core: parametrised register CPU core.
// Register file, single-cycle ALU with N/Z/C flags, a multi-cycle shift-add
// multiplier that stalls issue, and a registered output port with a
// one-cycle strobe.
module param_cpu_core #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 14,
  parameter int LOG_REGS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic [3:0]          opcode,
  input  logic [LOG_REGS-1:0] ra,
  input  logic [LOG_REGS-1:0] rb,
  input  logic [LOG_REGS-1:0] rc,
  input  logic [WIDTH-1:0]    imm,
  output logic [WIDTH-1:0]    data_out,
  output logic                out_valid,
  output logic [2:0]          status
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  typedef enum logic [3:0] {
    OP_MVR = 4'h0, OP_LDB = 4'h1, OP_STB = 4'h2, OP_RDS = 4'h3,
    OP_NOT = 4'h8, OP_AND = 4'h9, OP_ORA = 4'hA, OP_ADD = 4'hB,
    OP_SUB = 4'hC, OP_XOR = 4'hD, OP_INC = 4'hE, OP_MUL = 4'hF
  } op_t;

  state_t state, state_nxt;
  op_t    op;

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic                accept;
  logic [WIDTH-1:0]    src_a, src_b, src_d;
  logic [WIDTH:0]      ext;
  logic [WIDTH-1:0]    alu_res;
  logic                alu_c;

  logic [2*WIDTH-1:0]  mcand, acc, prod_nxt;
  logic [WIDTH-1:0]    mplier;
  logic [CW-1:0]       mul_cnt;
  logic [LOG_REGS-1:0] mul_dest;

  logic                rf_we;
  logic [LOG_REGS-1:0] rf_widx;
  logic [WIDTH-1:0]    rf_wdata;
  logic                flag_we, flag_c;
  logic                mul_start, mul_step;
  logic                out_we;
  logic [WIDTH-1:0]    out_data;

  function automatic logic in_range(input logic [LOG_REGS-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  assign op         = op_t'(opcode);
  assign inst_ready = (state == S_IDLE);
  assign accept     = inst_valid & inst_ready;

  // Unimplemented register indices read as zero.
  assign src_a = in_range(rb) ? regs[rb] : '0;
  assign src_b = in_range(rc) ? regs[rc] : '0;
  assign src_d = in_range(ra) ? regs[ra] : '0;

  // Multiplier step: add the shifted multiplicand when the current multiplier bit is set.
  assign prod_nxt = acc + (mplier[0] ? mcand : '0);

  // Single-cycle ALU result and carry/borrow.
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_NOT: alu_res = ~src_a;
      OP_AND: alu_res = src_a & src_b;
      OP_ORA: alu_res = src_a | src_b;
      OP_XOR: alu_res = src_a ^ src_b;
      OP_ADD: begin
        ext     = {1'b0, src_a} + {1'b0, src_b};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow.
        ext     = {1'b0, src_a} - {1'b0, src_b};
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      OP_INC: begin
        ext     = {1'b0, src_a} + (WIDTH + 1)'(1);
        alu_res = ext[WIDTH-1:0];
        alu_c   = ext[WIDTH];
      end
      default: ;
    endcase
  end

  // Next-state and write-control decode.
  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_widx   = ra;
    rf_wdata  = alu_res;
    flag_we   = 1'b0;
    flag_c    = alu_c;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    out_we    = 1'b0;
    out_data  = src_d;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MVR: begin rf_we = 1'b1; rf_wdata = src_a; end
            OP_LDB: begin rf_we = 1'b1; rf_wdata = imm; end
            OP_STB: out_we = 1'b1;
            OP_RDS: begin
              out_we   = 1'b1;
              out_data = {{(WIDTH-3){1'b0}}, status};
            end
            OP_NOT, OP_AND, OP_ORA, OP_ADD, OP_SUB, OP_XOR, OP_INC: begin
              rf_we   = 1'b1;
              flag_we = 1'b1;
            end
            OP_MUL: begin
              mul_start = 1'b1;
              state_nxt = S_MUL;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        mul_step = 1'b1;
        // Final step writes the product including this cycle's partial add.
        if (mul_cnt == MUL_LAST) begin
          rf_we     = 1'b1;
          rf_widx   = mul_dest;
          rf_wdata  = prod_nxt[WIDTH-1:0];
          flag_we   = 1'b1;
          flag_c    = |prod_nxt[2*WIDTH-1:WIDTH];
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Register file and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs   <= '{default: '0};
      status <= '0;
    end else begin
      if (rf_we && in_range(rf_widx)) regs[rf_widx] <= rf_wdata;
      if (flag_we) status <= {rf_wdata[WIDTH-1], rf_wdata == '0, flag_c};
    end
  end

  // Output port and its one-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_we;
      if (out_we) data_out <= out_data;
    end
  end

  // Shift-add multiplier datapath; operands are captured at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      mul_cnt  <= '0;
      mul_dest <= '0;
    end else if (mul_start) begin
      mcand    <= {{WIDTH{1'b0}}, src_a};
      mplier   <= src_b;
      acc      <= '0;
      mul_cnt  <= '0;
      mul_dest <= ra;
    end else if (mul_step) begin
      acc     <= prod_nxt;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      mul_cnt <= mul_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_param_cpu_core.sv
// Testbench for param_cpu_core: 8-bit/14-register instance checked against a
// behavioural model through an output scoreboard, plus a 16-bit instance with
// directed expectations.
module tb_param_cpu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, inst_ready, out_valid;
  logic [3:0]  opcode, ra, rb, rc;
  logic [7:0]  imm, data_out;
  logic [2:0]  status;

  logic        w_valid, w_ready, w_ovalid;
  logic [3:0]  w_op, w_ra, w_rb, w_rc;
  logic [15:0] w_imm, w_data;
  logic [2:0]  w_status;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb8[$];
  logic [31:0] sb16[$];
  logic [7:0]  mreg [16];
  logic [2:0]  mflags;

  always #5 clk = ~clk;

  param_cpu_core #(.WIDTH(8), .NUM_REGS(14), .LOG_REGS(4)) u_dut8 (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .opcode(opcode), .ra(ra), .rb(rb), .rc(rc), .imm(imm),
    .data_out(data_out), .out_valid(out_valid), .status(status)
  );

  param_cpu_core #(.WIDTH(16), .NUM_REGS(16), .LOG_REGS(4)) u_dut16 (
    .clk(clk), .rst(rst), .inst_valid(w_valid), .inst_ready(w_ready),
    .opcode(w_op), .ra(w_ra), .rb(w_rb), .rc(w_rc), .imm(w_imm),
    .data_out(w_data), .out_valid(w_ovalid), .status(w_status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboards: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb8.size() == 0) check("sb8_unexpected", 32'(out_valid), 32'd0);
      else                 check("sb8_data", 32'(data_out), sb8.pop_front());
    end
    if (w_ovalid) begin
      if (sb16.size() == 0) check("sb16_unexpected", 32'(w_ovalid), 32'd0);
      else                  check("sb16_data", 32'(w_data), sb16.pop_front());
    end
  end

  function automatic logic [7:0] mrd(input logic [3:0] i);
    return (i < 4'd14) ? mreg[i] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
    mflags = 3'b000;
  endtask

  // Reference behaviour of one accepted instruction (8-bit instance).
  task automatic model_exec(input logic [3:0] op, input logic [3:0] a, b, c, input logic [7:0] im);
    logic [15:0] x, y, p;
    logic [7:0]  r;
    logic        cf, wr;
    x = {8'h00, mrd(b)};
    y = {8'h00, mrd(c)};
    p = 16'h0; r = 8'h00; cf = 1'b0; wr = 1'b1;
    case (op)
      4'h0: r = mrd(b);
      4'h1: r = im;
      4'h2: begin sb8.push_back({24'h0, mrd(a)}); wr = 1'b0; end
      4'h3: begin sb8.push_back({29'h0, mflags}); wr = 1'b0; end
      4'h4, 4'h5, 4'h6, 4'h7: wr = 1'b0;
      4'h8: p = ~x;
      4'h9: p = x & y;
      4'hA: p = x | y;
      4'hB: begin p = x + y; cf = p[8]; end
      4'hC: begin p = x - y; cf = (x < y); end
      4'hD: p = x ^ y;
      4'hE: begin p = x + 16'd1; cf = p[8]; end
      default: begin p = x * y; cf = (p[15:8] != 8'h00); end
    endcase
    if (op >= 4'h8) begin
      r = p[7:0];
      mflags = {r[7], r == 8'h00, cf};
    end
    if (wr && a < 4'd14) mreg[a] = r;
  endtask

  // Hold an instruction until accepted; waits = cycles spent stalled.
  task automatic issue(input logic [3:0] op, a, b, c, input logic [7:0] im, output int waits);
    logic rdy;
    opcode = op; ra = a; rb = b; rc = c; imm = im;
    inst_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      rdy = inst_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 40) begin
        check("issue8_timeout", 32'(rdy), 32'd1);
        break;
      end
    end
    inst_valid = 1'b0;
    if (rdy) model_exec(op, a, b, c, im);
  endtask

  task automatic op8(input logic [3:0] op, a, b, c, input logic [7:0] im);
    int w;
    issue(op, a, b, c, im, w);
  endtask

  task automatic issue16(input logic [3:0] op, a, b, c, input logic [15:0] im, output int waits);
    logic rdy;
    w_op = op; w_ra = a; w_rb = b; w_rc = c; w_imm = im;
    w_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      rdy = w_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 40) begin
        check("issue16_timeout", 32'(rdy), 32'd1);
        break;
      end
    end
    w_valid = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    inst_valid = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0; imm = '0;
    w_valid = 1'b0; w_op = '0; w_ra = '0; w_rb = '0; w_rc = '0; w_imm = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready", 32'(inst_ready), 32'd1);
    check("rst_status", 32'(status), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_ovalid", 32'(out_valid), 32'd0);

    // All registers read zero after reset.
    for (int i = 0; i < 14; i++) op8(4'h2, 4'(i), 4'h0, 4'h0, 8'h00);
    check("t1_status", 32'(status), 32'd0);

    // ADD with carry-out, then RDS.
    op8(4'h1, 4'd1, 4'd0, 4'd0, 8'hF0);
    op8(4'h1, 4'd2, 4'd0, 4'd0, 8'h20);
    op8(4'hB, 4'd3, 4'd1, 4'd2, 8'h00);
    check("t2_add_flags", 32'(status), 32'b001);
    op8(4'h2, 4'd3, 4'd0, 4'd0, 8'h00);
    op8(4'h3, 4'd0, 4'd0, 4'd0, 8'h00);

    // SUB zero, SUB borrow, INC wrap.
    op8(4'h1, 4'd4, 4'd0, 4'd0, 8'h05);
    op8(4'hC, 4'd5, 4'd4, 4'd4, 8'h00);
    check("t3_sub_zero", 32'(status), 32'b010);
    op8(4'hC, 4'd6, 4'd4, 4'd1, 8'h00);
    check("t3_sub_borrow", 32'(status), 32'b001);
    op8(4'h2, 4'd6, 4'd0, 4'd0, 8'h00);
    op8(4'h1, 4'd7, 4'd0, 4'd0, 8'hFF);
    op8(4'hE, 4'd8, 4'd7, 4'd0, 8'h00);
    check("t3_inc_wrap", 32'(status), 32'b011);
    op8(4'h2, 4'd8, 4'd0, 4'd0, 8'h00);

    // Multiplier latency, busy stall and flags.
    op8(4'h1, 4'd1, 4'd0, 4'd0, 8'h0D);
    op8(4'h1, 4'd2, 4'd0, 4'd0, 8'h0B);
    issue(4'hF, 4'd3, 4'd1, 4'd2, 8'h00, w);
    check("t4_mul_accept", 32'(w), 32'd0);
    issue(4'h2, 4'd3, 4'd0, 4'd0, 8'h00, w);
    check("t4_mul_busy", 32'(w), 32'd8);
    check("t4_mul_flags", 32'(status), 32'b100);
    op8(4'h1, 4'd1, 4'd0, 4'd0, 8'h10);
    op8(4'h1, 4'd2, 4'd0, 4'd0, 8'h10);
    op8(4'hF, 4'd3, 4'd1, 4'd2, 8'h00);
    issue(4'h3, 4'd0, 4'd0, 4'd0, 8'h00, w);
    check("t4_mul2_busy", 32'(w), 32'd8);
    check("t4_mul2_flags", 32'(status), 32'b011);
    op8(4'h2, 4'd3, 4'd0, 4'd0, 8'h00);

    // Same register as sources and destination.
    op8(4'h1, 4'd9, 4'd0, 4'd0, 8'h81);
    op8(4'hB, 4'd9, 4'd9, 4'd9, 8'h00);
    check("same_reg_flags", 32'(status), 32'b001);
    op8(4'h2, 4'd9, 4'd0, 4'd0, 8'h00);

    // Unimplemented registers: writes dropped, reads zero, flags still update.
    op8(4'h1, 4'd14, 4'd0, 4'd0, 8'h55);
    op8(4'h2, 4'd14, 4'd0, 4'd0, 8'h00);
    op8(4'h0, 4'd10, 4'd15, 4'd0, 8'h00);
    op8(4'h2, 4'd10, 4'd0, 4'd0, 8'h00);
    op8(4'hB, 4'd15, 4'd1, 4'd1, 8'h00);
    check("oor_flags", 32'(status), 32'b000);
    op8(4'h6, 4'd1, 4'd0, 4'd0, 8'h00);
    op8(4'h3, 4'd0, 4'd0, 4'd0, 8'h00);

    // Reset in the middle of a multiply aborts it.
    op8(4'h1, 4'd1, 4'd0, 4'd0, 8'h0D);
    op8(4'h1, 4'd2, 4'd0, 4'd0, 8'h0B);
    issue(4'hF, 4'd11, 4'd1, 4'd2, 8'h00, w);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    sb8.delete();
    check("t5_ready", 32'(inst_ready), 32'd1);
    check("t5_status", 32'(status), 32'd0);
    op8(4'h2, 4'd11, 4'd0, 4'd0, 8'h00);
    op8(4'h2, 4'd1, 4'd0, 4'd0, 8'h00);

    // Random instruction mix against the model, then dump every register.
    repeat (120)
      op8(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 8'($urandom));
    for (int i = 0; i < 16; i++) op8(4'h2, 4'(i), 4'h0, 4'h0, 8'h00);
    op8(4'h3, 4'd0, 4'd0, 4'd0, 8'h00);

    // 16-bit, 16-register instance.
    issue16(4'h1, 4'd1, 4'd0, 4'd0, 16'h0123, w);
    issue16(4'h1, 4'd2, 4'd0, 4'd0, 16'h0100, w);
    issue16(4'hF, 4'd3, 4'd1, 4'd2, 16'h0000, w);
    issue16(4'h2, 4'd3, 4'd0, 4'd0, 16'h0000, w);
    sb16.push_back(32'h2300);
    check("w16_mul_busy", 32'(w), 32'd16);
    check("w16_mul_flags", 32'(w_status), 32'b001);
    issue16(4'h3, 4'd0, 4'd0, 4'd0, 16'h0000, w);
    sb16.push_back(32'h0001);
    issue16(4'h1, 4'd15, 4'd0, 4'd0, 16'hBEEF, w);
    issue16(4'h2, 4'd15, 4'd0, 4'd0, 16'h0000, w);
    sb16.push_back(32'hBEEF);

    repeat (4) @(posedge clk);
    #1;
    check("sb8_drain", 32'(sb8.size()), 32'd0);
    check("sb16_drain", 32'(sb16.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
